// File: rtl/tlut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlut_pkg
// Brief    : Shared defaults, width helpers and sideband record for the
//            TLUT product-reduction adder tree.
// Revision : 1.0  initial pipelined, parametrised release
// ============================================================================
package tlut_pkg;

    localparam int c_def_dim_c        = 8;
    localparam int c_def_dim_a        = 8;
    localparam int c_def_acc_width    = 24;
    localparam int c_def_stage_stride = 1;
    localparam int c_def_acc_ext      = 8;

    // Control information that travels alongside each beat through the tree
    typedef struct packed {
        logic acc_mode;
        logic first;
        logic last;
        logic valid;
    } sband_t;

    // Number of adder levels; a single leaf needs no adder at all
    function automatic int tree_levels(input int dim_c);
        return (dim_c > 1) ? $clog2(dim_c) : 0;
    endfunction

    // Register stages inside the tree (at least one, even for a direct pass)
    function automatic int tree_latency(input int dim_c, input int stride);
        int lv;
        lv = tree_levels(dim_c);
        return (lv == 0) ? 1 : (lv + stride - 1) / stride;
    endfunction

    // Exact tree-output width: one growth bit per level
    function automatic int sum_width(input int acc_width, input int dim_c);
        return acc_width + tree_levels(dim_c);
    endfunction

    // Output width including accumulation guard bits
    function automatic int res_width(input int acc_width, input int dim_c, input int acc_ext);
        return sum_width(acc_width, dim_c) + acc_ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlut_tree_col.sv
`default_nettype none
// ============================================================================
// Module   : tlut_tree_col
// Brief    : Single-column pipelined signed binary adder tree. Leaves are
//            zero-padded to a power of two; each level grows by one bit.
//            Registers sit after every STAGE_STRIDE-th level and always
//            after the final level.
// Revision : 1.0  initial pipelined, parametrised release
// ============================================================================
module tlut_tree_col
    import tlut_pkg::*;
#(
    parameter int DIM_C        = c_def_dim_c,
    parameter int ACC_WIDTH    = c_def_acc_width,
    parameter int STAGE_STRIDE = c_def_stage_stride,
    parameter int SUM_WIDTH    = sum_width(ACC_WIDTH, DIM_C)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [DIM_C*ACC_WIDTH-1:0]    leaves,
    output logic signed [SUM_WIDTH-1:0]   sum
);

    localparam int c_levels = tree_levels(DIM_C);
    localparam int c_pad    = 1 << c_levels;

    // Bit offset of a level inside the flattened tree vector
    function automatic int lvl_off(input int k, input int pad, input int w);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) begin
            o += (pad >> i) * (w + i);
        end
        return o;
    endfunction

    localparam int c_total = lvl_off(c_levels + 1, c_pad, ACC_WIDTH);

    // All node values of all levels, level 0 at the bottom
    logic [c_total-1:0] w_tree;

    for (genvar k = 0; k <= c_levels; k++) begin : g_lvl
        localparam int c_w   = ACC_WIDTH + k;
        localparam int c_n   = c_pad >> k;
        localparam int c_o   = lvl_off(k, c_pad, ACC_WIDTH);
        localparam bit c_reg = (k == c_levels) || ((k != 0) && ((k % STAGE_STRIDE) == 0));

        logic [c_n*c_w-1:0] w_comb;

        for (genvar j = 0; j < c_n; j++) begin : g_node
            if (k == 0) begin : g_leaf
                if (j < DIM_C) begin : g_real
                    assign w_comb[j*c_w +: c_w] = leaves[j*ACC_WIDTH +: ACC_WIDTH];
                end else begin : g_zero
                    assign w_comb[j*c_w +: c_w] = '0;
                end
            end else begin : g_add
                localparam int c_po = lvl_off(k - 1, c_pad, ACC_WIDTH);
                localparam int c_pw = c_w - 1;
                logic [c_pw-1:0] w_a;
                logic [c_pw-1:0] w_b;
                assign w_a = w_tree[c_po + (2*j)*c_pw +: c_pw];
                assign w_b = w_tree[c_po + (2*j+1)*c_pw +: c_pw];
                // Sign-extend both operands by one bit so the sum cannot overflow
                assign w_comb[j*c_w +: c_w] = {w_a[c_pw-1], w_a} + {w_b[c_pw-1], w_b};
            end
        end

        if (c_reg) begin : g_reg
            logic [c_n*c_w-1:0] r_node;
            // Pipeline register for this level; frozen while downstream stalls
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_node <= '0;
                end else if (!stall) begin
                    r_node <= w_comb;
                end
            end
            assign w_tree[c_o +: c_n*c_w] = r_node;
        end else begin : g_comb
            assign w_tree[c_o +: c_n*c_w] = w_comb;
        end
    end

    assign sum = w_tree[lvl_off(c_levels, c_pad, ACC_WIDTH) +: SUM_WIDTH];

endmodule
`default_nettype wire

// File: rtl/tlut_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tlut_adder_tree_pipe
// Brief    : DIM_A parallel pipelined adder trees reducing DIM_C signed TLUT
//            products per column, followed by an output stage that either
//            passes the sum through or accumulates it across tiles.
//            Valid/ready on both sides; a held output stalls the whole pipe.
// Revision : 1.0  initial pipelined, parametrised release
// ============================================================================
module tlut_adder_tree_pipe
    import tlut_pkg::*;
#(
    parameter int DIM_C        = c_def_dim_c,
    parameter int DIM_A        = c_def_dim_a,
    parameter int ACC_WIDTH    = c_def_acc_width,
    parameter int STAGE_STRIDE = c_def_stage_stride,
    parameter int ACC_EXT      = c_def_acc_ext,
    parameter int SUM_WIDTH    = sum_width(ACC_WIDTH, DIM_C),
    parameter int RES_WIDTH    = SUM_WIDTH + ACC_EXT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   prod,
    input  logic                               in_acc_mode,
    input  logic                               in_first,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DIM_A*RES_WIDTH-1:0]         mult
);

    localparam int c_lat = tree_latency(DIM_C, STAGE_STRIDE);

    logic                         r_out_valid;
    logic [DIM_A*RES_WIDTH-1:0]   r_mult;
    logic signed [RES_WIDTH-1:0]  r_acc      [DIM_A];
    sband_t                       r_sb       [c_lat];
    sband_t                       w_sb_out;
    logic                         w_stall;
    logic signed [SUM_WIDTH-1:0]  w_sum      [DIM_A];
    logic signed [RES_WIDTH-1:0]  w_ext      [DIM_A];
    logic signed [RES_WIDTH-1:0]  w_acc_next [DIM_A];

    // A result waiting on a busy consumer freezes everything upstream
    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~rst & ~w_stall;
    assign out_valid = r_out_valid;
    assign mult      = r_mult;
    assign w_sb_out  = r_sb[c_lat-1];

    for (genvar a = 0; a < DIM_A; a++) begin : g_col
        logic [DIM_C*ACC_WIDTH-1:0] w_leaves;
        // Gather column a out of the [DIM_C][DIM_A] product array
        for (genvar c = 0; c < DIM_C; c++) begin : g_leaf
            assign w_leaves[c*ACC_WIDTH +: ACC_WIDTH] = prod[(c*DIM_A + a)*ACC_WIDTH +: ACC_WIDTH];
        end
        tlut_tree_col #(
            .DIM_C        (DIM_C),
            .ACC_WIDTH    (ACC_WIDTH),
            .STAGE_STRIDE (STAGE_STRIDE),
            .SUM_WIDTH    (SUM_WIDTH)
        ) u_col (
            .clk    (clk),
            .rst    (rst),
            .stall  (w_stall),
            .leaves (w_leaves),
            .sum    (w_sum[a])
        );
    end

    // Sideband shift register kept in lock-step with the tree registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_lat; i++) begin
                r_sb[i] <= '0;
            end
        end else if (!w_stall) begin
            r_sb[0] <= '{acc_mode: in_acc_mode,
                         first:    in_first,
                         last:     in_last,
                         valid:    in_valid & in_ready};
            for (int i = 1; i < c_lat; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    // Sign-extended tree result and the candidate new accumulator value
    always_comb begin
        for (int a = 0; a < DIM_A; a++) begin
            w_ext[a]      = RES_WIDTH'(w_sum[a]);
            w_acc_next[a] = w_sb_out.first ? w_ext[a] : (r_acc[a] + w_ext[a]);
        end
    end

    // Output stage: pass-through or tile accumulation, held during stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_mult      <= '0;
            for (int a = 0; a < DIM_A; a++) begin
                r_acc[a] <= '0;
            end
        end else if (!w_stall) begin
            r_out_valid <= 1'b0;
            if (w_sb_out.valid) begin
                if (!w_sb_out.acc_mode) begin
                    // Pass-through leaves the accumulator untouched
                    r_out_valid <= 1'b1;
                    for (int a = 0; a < DIM_A; a++) begin
                        r_mult[a*RES_WIDTH +: RES_WIDTH] <= w_ext[a];
                    end
                end else begin
                    for (int a = 0; a < DIM_A; a++) begin
                        r_acc[a] <= w_acc_next[a];
                    end
                    if (w_sb_out.last) begin
                        r_out_valid <= 1'b1;
                        for (int a = 0; a < DIM_A; a++) begin
                            r_mult[a*RES_WIDTH +: RES_WIDTH] <= w_acc_next[a];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlut_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlut_adder_tree_pipe
// Brief    : Directed bench: table of pass-through vectors, accumulate
//            groups, backpressure, odd leaf count with stride 2, reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_tlut_adder_tree_pipe;

    localparam int DC  = 8;
    localparam int DA  = 8;
    localparam int AW  = 24;
    localparam int RW  = 35;
    localparam int DC5 = 5;
    localparam int DA5 = 2;
    localparam int RW5 = 35;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  in_valid, in_ready, in_acc_mode, in_first, in_last;
    logic                  out_valid, out_ready;
    logic [DC*DA*AW-1:0]   prod;
    logic [DA*RW-1:0]      mult;

    logic                  in_valid5, in_ready5, out_valid5, out_ready5;
    logic [DC5*DA5*AW-1:0] prod5;
    logic [DA5*RW5-1:0]    mult5;

    tlut_adder_tree_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
        .in_acc_mode(in_acc_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .mult(mult)
    );

    tlut_adder_tree_pipe #(.DIM_C(DC5), .DIM_A(DA5), .STAGE_STRIDE(2)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .prod(prod5),
        .in_acc_mode(1'b0), .in_first(1'b0), .in_last(1'b0),
        .out_valid(out_valid5), .out_ready(out_ready5), .mult(mult5)
    );

    typedef struct packed {
        logic [7:0][23:0]   leaf;
        logic signed [23:0] lane_add;  // added to leaf 0 once per lane index
        logic signed [63:0] exp0;      // expected lane-0 result
    } vec_t;

    vec_t tbl [6];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane(input int a);
        logic signed [RW-1:0] v;
        v = mult[a*RW +: RW];
        return v;
    endfunction

    function automatic longint lane5(input int a);
        logic signed [RW5-1:0] v;
        v = mult5[a*RW5 +: RW5];
        return v;
    endfunction

    task automatic set_beat(input logic [7:0][23:0] lf, input int la);
        for (int c = 0; c < DC; c++) begin
            for (int a = 0; a < DA; a++) begin
                prod[(c*DA + a)*AW +: AW] = lf[c] + ((c == 0) ? 24'(a*la) : 24'd0);
            end
        end
    endtask

    task automatic set_uniform(input int v, input int la);
        logic [7:0][23:0] lf;
        lf    = '0;
        lf[0] = 24'(v);
        set_beat(lf, la);
    endtask

    // One accepted beat; returns at posedge+1 after the accepting edge
    task automatic drive(input int v, input logic m, input logic f, input logic l);
        set_uniform(v, 0);
        in_acc_mode = m;
        in_first    = f;
        in_last     = l;
        in_valid    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic watch(input int n, output int pulses, output longint first_v, output longint last_v);
        pulses  = 0;
        first_v = 0;
        last_v  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (pulses == 0) first_v = lane(0);
                last_v = lane(DA-1);
                pulses++;
            end
        end
    endtask

    initial begin : main
        int     lat, pulses, bi, got, hold;
        longint fv, lv, held;
        bit     started, acc;

        tbl[0].leaf = {8{24'd1}};              tbl[0].lane_add = 0;  tbl[0].exp0 = 8;
        tbl[1].leaf = {8{24'h800000}};         tbl[1].lane_add = 0;  tbl[1].exp0 = -67108864;
        tbl[2].leaf = {4{24'hFFFFFD, 24'd5}};  tbl[2].lane_add = 0;  tbl[2].exp0 = 8;
        tbl[3].leaf = {8{24'h7FFFFF}};         tbl[3].lane_add = 0;  tbl[3].exp0 = 67108856;
        tbl[4].leaf = {24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
        tbl[4].lane_add = 3;                   tbl[4].exp0 = 36;
        tbl[5].leaf = {{7{24'd0}}, 24'hFFFFFF}; tbl[5].lane_add = -2; tbl[5].exp0 = -1;

        rst = 1'b1; in_valid = 0; in_acc_mode = 0; in_first = 0; in_last = 0;
        out_ready = 1; prod = '0; in_valid5 = 0; out_ready5 = 1; prod5 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_mult0", lane(0), 0);
        check("rst_mult7", lane(7), 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Pass-through vector table
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            set_beat(tbl[t].leaf, int'(tbl[t].lane_add));
            in_acc_mode = 0; in_first = 0; in_last = 0; in_valid = 1;
            @(posedge clk); #1;
            in_valid = 0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", t), lat, 4);
            check($sformatf("vec%0d_lane0", t), lane(0), tbl[t].exp0);
            check($sformatf("vec%0d_lane3", t), lane(3), tbl[t].exp0 + 3*longint'(tbl[t].lane_add));
            check($sformatf("vec%0d_lane7", t), lane(7), tbl[t].exp0 + 7*longint'(tbl[t].lane_add));
            @(posedge clk); #1;
            check($sformatf("vec%0d_one_pulse", t), out_valid, 0);
        end

        // Accumulate group 10 + 20 - 5
        drive(10, 1, 1, 0); drive(20, 1, 0, 0); drive(-5, 1, 0, 1);
        in_valid = 0;
        watch(10, pulses, fv, lv);
        check("acc3_pulses", pulses, 1);
        check("acc3_lane0", fv, 25);
        check("acc3_lane7", lv, 25);

        // Single-tile group
        drive(7, 1, 1, 1);
        in_valid = 0;
        watch(10, pulses, fv, lv);
        check("acc1_pulses", pulses, 1);
        check("acc1_value", lv, 7);

        // Pass-through beat in the middle of a group
        drive(10, 1, 1, 0); drive(100, 0, 0, 0); drive(5, 1, 0, 1);
        in_valid = 0;
        watch(10, pulses, fv, lv);
        check("mix_pulses", pulses, 2);
        check("mix_passthru", fv, 100);
        check("mix_acc", lv, 15);

        // Accumulate without first continues from the held total
        drive(3, 1, 0, 1);
        in_valid = 0;
        watch(10, pulses, fv, lv);
        check("nofirst_pulses", pulses, 1);
        check("nofirst_value", lv, 18);

        // Backpressure: six beats, consumer stalls 5 cycles at the first result
        bi = 0; got = 0; hold = 0; started = 0; held = 0;
        in_acc_mode = 0; in_first = 0; in_last = 0;
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
            if (out_valid && !started) begin
                started = 1;
                hold    = 5;
            end
            out_ready = (hold == 0);
            in_valid  = (bi < 6);
            if (bi < 6) set_uniform(100 + bi, 1);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (!out_ready) begin
                    if (hold == 5) begin
                        held = lane(0);
                        check("bp_held_first", held, 100);
                    end else begin
                        check("bp_mult_stable", lane(0), held);
                    end
                    check("bp_in_ready_low", in_ready, 0);
                    hold--;
                end else begin
                    check($sformatf("bp_res%0d_lane0", got), lane(0), 100 + got);
                    check($sformatf("bp_res%0d_lane7", got), lane(7), 107 + got);
                    got++;
                end
            end
            @(posedge clk); #1;
            if (acc) bi++;
        end
        in_valid = 0; out_ready = 1;
        check("bp_count", got, 6);
        check("bp_stalled", hold, 0);
        watch(6, pulses, fv, lv);
        check("bp_no_duplicates", pulses, 0);

        // Odd leaf count, stride 2
        @(posedge clk); #1;
        for (int c = 0; c < DC5; c++) begin
            prod5[(c*DA5 + 0)*AW +: AW] = 24'(c + 1);
            prod5[(c*DA5 + 1)*AW +: AW] = 24'(-(c + 1));
        end
        in_valid5 = 1;
        @(posedge clk); #1;
        in_valid5 = 0;
        lat = 1;
        while (!out_valid5 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dc5_latency", lat, 3);
        check("dc5_lane0", lane5(0), 15);
        check("dc5_lane1", lane5(1), -15);

        // Reset with a partial accumulation and three beats in flight
        drive(50, 1, 1, 0); drive(1, 1, 0, 0); drive(2, 1, 0, 1); drive(9, 0, 0, 0);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_mult0", lane(0), 0);
        check("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(4, 1, 1, 0); drive(6, 1, 0, 1);
        in_valid = 0;
        watch(12, pulses, fv, lv);
        check("after_rst_pulses", pulses, 1);
        check("after_rst_value", lv, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
